// File: rtl/flag_unit_pkg.sv
// Shared status-flag definitions used by the flag unit and the control/branch logic.
package flag_unit_pkg;
    localparam int FLAG_W = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/flag_unit_stack.sv
// Parametrised LIFO for flag context save/restore; strobes arrive pre-qualified.
module flag_stack
    import flag_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout,
    output logic [CNT_W-1:0] cnt,
    output logic             empty,
    output logic             full
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t           mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] cnt_m1;

    // Indices only matter while the matching strobe is legal (not full / not empty).
    assign cnt_m1 = cnt - 1'b1;
    assign wr_idx = IDX_W'(cnt);
    assign rd_idx = IDX_W'(cnt_m1);

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign dout  = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + 1'b1;
        else if (pop && !empty)
            cnt <= cnt_m1;
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= din;
    end
endmodule

// File: rtl/flag_unit.sv
// Status-flag register: ALU flag capture, software write and LIFO context stack.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [DATA_W:0]   alu_data,
    input  logic              src_a_msb,
    input  logic              src_b_msb,
    input  logic              alu_sub,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic              wr_en,
    input  logic [FLAG_W-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    output logic [FLAG_W-1:0] flag_reg,
    output logic [CNT_W-1:0]  stk_cnt,
    output logic              stk_empty,
    output logic              stk_full,
    output logic              stk_err
);
    flags_t alu_flags;
    flags_t alu_upd;
    flags_t stk_top;
    flags_t flag_next;
    logic   b_eff;
    logic   push_q;
    logic   pop_q;
    logic   err_set;

    assign b_eff = src_b_msb ^ alu_sub;

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = ~|alu_data[DATA_W-1:0];
        alu_flags[FLAG_N] = alu_data[DATA_W-1];
        alu_flags[FLAG_C] = alu_data[DATA_W];
        alu_flags[FLAG_V] = (src_a_msb == b_eff) && (alu_data[DATA_W-1] != src_a_msb);
    end

    assign alu_upd = (alu_flags & flag_we) | (flag_reg & ~flag_we);

    // Simultaneous push+pop is treated as a conflict: neither reaches the stack.
    assign push_q  = push && !pop && !stk_full;
    assign pop_q   = pop && !push && !stk_empty;
    assign err_set = (push && pop) || (push && !pop && stk_full) || (pop && !push && stk_empty);

    always_comb begin
        flag_next = flag_reg;
        if (pop_q)
            flag_next = stk_top;
        else if (wr_en)
            flag_next = wr_data;
        else if (alu_valid)
            flag_next = alu_upd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_reg <= '0;
            stk_err  <= 1'b0;
        end else begin
            flag_reg <= flag_next;
            if (err_set)
                stk_err <= 1'b1;
        end
    end

    flag_stack #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (pop_q),
        .din   (flag_reg),
        .dout  (stk_top),
        .cnt   (stk_cnt),
        .empty (stk_empty),
        .full  (stk_full)
    );
endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit with hand-computed expected flags.
module tb_flag_unit;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic [DATA_W:0]   alu_data;
    logic              src_a_msb;
    logic              src_b_msb;
    logic              alu_sub;
    logic [3:0]        flag_we;
    logic              wr_en;
    logic [3:0]        wr_data;
    logic              push;
    logic              pop;
    logic [3:0]        flag_reg;
    logic [CNT_W-1:0]  stk_cnt;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flag_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .src_a_msb (src_a_msb),
        .src_b_msb (src_b_msb),
        .alu_sub   (alu_sub),
        .flag_we   (flag_we),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .push      (push),
        .pop       (pop),
        .flag_reg  (flag_reg),
        .stk_cnt   (stk_cnt),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply current inputs for one clock edge, then return strobes to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        wr_en     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
    endtask

    task automatic alu(input logic [8:0] d, input logic a, input logic b, input logic s,
                       input logic [3:0] we);
        alu_valid = 1'b1;
        alu_data  = d;
        src_a_msb = a;
        src_b_msb = b;
        alu_sub   = s;
        flag_we   = we;
    endtask

    task automatic swr(input logic [3:0] v);
        wr_en   = 1'b1;
        wr_data = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; alu_valid = 1'b0; alu_data = '0; src_a_msb = 1'b0;
        src_b_msb = 1'b0; alu_sub = 1'b0; flag_we = '0; wr_en = 1'b0;
        wr_data = '0; push = 1'b0; pop = 1'b0;
        do_reset();
        chk("rst_flags", 8'(flag_reg), 8'b0000);
        chk("rst_empty", 8'(stk_empty), 8'd1);
        chk("rst_full",  8'(stk_full), 8'd0);

        // Zero result with carry; neg+neg giving positive sets V by formula.
        alu(9'h100, 1'b1, 1'b1, 1'b0, 4'b1111); tick();
        chk("alu_zc", 8'(flag_reg), 8'b1011);
        alu(9'h080, 1'b0, 1'b0, 1'b0, 4'b1111); tick();
        chk("alu_ovf_add", 8'(flag_reg), 8'b0101);
        alu(9'h07F, 1'b1, 1'b0, 1'b1, 4'b1111); tick();
        chk("alu_ovf_sub", 8'(flag_reg), 8'b0001);
        swr(4'b0101); tick();
        chk("sw_write", 8'(flag_reg), 8'b0101);
        alu(9'h1FF, 1'b0, 1'b0, 1'b0, 4'b0010); tick();
        chk("alu_mask", 8'(flag_reg), 8'b0111);

        // Reset with two saved entries discards them.
        push = 1'b1; tick();
        push = 1'b1; tick();
        chk("pre_rst_cnt", 8'(stk_cnt), 8'd2);
        do_reset();
        chk("midrst_flags", 8'(flag_reg), 8'b0000);
        chk("midrst_cnt",   8'(stk_cnt), 8'd0);
        chk("midrst_empty", 8'(stk_empty), 8'd1);
        chk("midrst_err",   8'(stk_err), 8'd0);

        swr(4'b1001); tick(); push = 1'b1; tick();
        swr(4'b0110); tick(); push = 1'b1; tick();
        swr(4'b0011); tick(); push = 1'b1; tick();
        swr(4'b1100); tick(); push = 1'b1; tick();
        chk("full_flag", 8'(stk_full), 8'd1);
        chk("full_cnt",  8'(stk_cnt), 8'd4);
        chk("full_err",  8'(stk_err), 8'd0);
        push = 1'b1; swr(4'b1111); tick();
        chk("ovf_err",   8'(stk_err), 8'd1);
        chk("ovf_cnt",   8'(stk_cnt), 8'd4);
        chk("ovf_flags", 8'(flag_reg), 8'b1111);

        // Pop wins over a simultaneous ALU update.
        pop = 1'b1; alu(9'h000, 1'b0, 1'b0, 1'b0, 4'b1111); tick();
        chk("pop1_alu", 8'(flag_reg), 8'b1100);
        pop = 1'b1; tick();
        chk("pop2", 8'(flag_reg), 8'b0011);
        pop = 1'b1; tick();
        chk("pop3", 8'(flag_reg), 8'b0110);
        pop = 1'b1; tick();
        chk("pop4", 8'(flag_reg), 8'b1001);
        chk("pop_empty", 8'(stk_empty), 8'd1);
        chk("pop_cnt",   8'(stk_cnt), 8'd0);

        do_reset();
        pop = 1'b1; swr(4'b0011); tick();
        chk("udf_flags", 8'(flag_reg), 8'b0011);
        chk("udf_err",   8'(stk_err), 8'd1);
        chk("udf_cnt",   8'(stk_cnt), 8'd0);

        // Push saves the pre-update value while the write still lands.
        do_reset();
        swr(4'b0110); tick();
        push = 1'b1; swr(4'b1111); tick();
        chk("pushwr_flags", 8'(flag_reg), 8'b1111);
        chk("pushwr_cnt",   8'(stk_cnt), 8'd1);
        pop = 1'b1; tick();
        chk("pushwr_pop", 8'(flag_reg), 8'b0110);

        push = 1'b1; tick();
        chk("pp_pre_cnt", 8'(stk_cnt), 8'd1);
        push = 1'b1; pop = 1'b1; swr(4'b1010); tick();
        chk("pp_cnt",   8'(stk_cnt), 8'd1);
        chk("pp_err",   8'(stk_err), 8'd1);
        chk("pp_flags", 8'(flag_reg), 8'b1010);
        chk("pp_empty", 8'(stk_empty), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
